// File: rtl/decode38_hold_pkg.sv
// Shared FSM encoding and counter sizing for the hold-style one-hot decoder.
// Both the HOLD and GAP phases are timed by one down-counter sized here.
package decode38_hold_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Counter must represent max(hold, gap); never narrower than one bit.
   function automatic int cnt_width(input int hold, input int gap);
      int m;
      int w;
      m = (hold > gap) ? hold : gap;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/decode38_hold_dec_onehot.sv
// Combinational N-to-2**N one-hot decoder with an enable gate.
// Output is all-zero when disabled, so at most one bit is ever set.
module dec_onehot #(
   parameter int N = 3
) (
   input  logic            en_i,
   input  logic [N-1:0]    code_i,
   output logic [2**N-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[code_i] = 1'b1;
      end
   end

endmodule

// File: rtl/decode38_hold.sv
// Registered one-hot decoder: holds the decoded line HOLD cycles, then forces
// GAP all-zero cycles; in_ready is low for the whole hold+gap window.
module decode38_hold
   import decode38_hold_pkg::*;
#(
   parameter int N    = 3,
   parameter int HOLD = 4,
   parameter int GAP  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    code,
   output logic [2**N-1:0] y,
   output logic            y_valid,
   output logic            done
);

   localparam int W  = 2**N;
   localparam int CW = cnt_width(HOLD, GAP);

   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  y_q, y_d;
   logic [W-1:0]  dec_y;
   logic          accept;
   logic          cnt_zero;

   assign in_ready = en && (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign cnt_zero = (cnt_q == '0);

   // Decoder only enabled on accept, so code is looked at nowhere else.
   dec_onehot #(
      .N (N)
   ) u_dec (
      .en_i     (accept),
      .code_i   (code),
      .onehot_o (dec_y)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         y_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
                  y_d     = dec_y;
               end
            end
            ST_HOLD: begin
               if (cnt_zero) begin
                  y_d = '0;
                  if (GAP > 0) begin
                     state_d = ST_GAP;
                     cnt_d   = GAP_LD;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_GAP: begin
               y_d = '0;
               if (cnt_zero) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               y_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   // done depends only on flopped state plus en, so reset clears it at once.
   assign done    = en && (state_q == ST_HOLD) && cnt_zero;
   assign y       = y_q;
   assign y_valid = |y_q;

endmodule

// File: tb/tb_decode38_hold.sv
// Bench for decode38_hold: a default instance and a HOLD=1/GAP=0 instance share
// stimulus; both are checked each cycle against a timeline-based reference.
module tb_decode38_hold;

   localparam int N = 3;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         in_valid;
   logic [N-1:0] code;

   logic         rdy0, yv0, done0;
   logic         rdy1, yv1, done1;
   logic [W-1:0] y0, y1;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // reference: last accept time/code per instance; active cleared on abort
   bit act      [2];
   int acc_t    [2];
   int acc_code [2];

   // samples taken at the mid-cycle check of the last step
   logic [W-1:0] s_y0, s_y1;
   logic         s_rdy0, s_done0, s_rdy1, s_done1;

   always #5 clk = ~clk;

   decode38_hold #(.N(3), .HOLD(4), .GAP(1)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy0),
      .code(code), .y(y0), .y_valid(yv0), .done(done0)
   );

   decode38_hold #(.N(3), .HOLD(1), .GAP(0)) dut_fast (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1),
      .code(code), .y(y1), .y_valid(yv1), .done(done1)
   );

   function automatic int hp(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic int gp(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic bit m_busy(input int d);
      int age;
      age = cyc - acc_t[d];
      return act[d] && (age >= 1) && (age <= hp(d) + gp(d));
   endfunction

   function automatic logic [W-1:0] m_y(input int d);
      logic [W-1:0] v;
      int age;
      v   = '0;
      age = cyc - acc_t[d];
      if (act[d] && age >= 1 && age <= hp(d)) v[acc_code[d]] = 1'b1;
      return v;
   endfunction

   function automatic logic m_rdy(input int d);
      return en && !m_busy(d);
   endfunction

   function automatic logic m_done(input int d);
      return act[d] && ((cyc - acc_t[d]) == hp(d)) && en;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // one clock: check both instances mid-cycle, advance the reference, next edge
   task automatic step();
      @(negedge clk);
      s_y0 = y0; s_rdy0 = rdy0; s_done0 = done0;
      s_y1 = y1; s_rdy1 = rdy1; s_done1 = done1;
      chk("y0",     y0,    m_y(0));
      chk("yv0",    yv0,   {7'd0, |m_y(0)});
      chk("done0",  done0, {7'd0, m_done(0)});
      chk("rdy0",   rdy0,  {7'd0, m_rdy(0)});
      chk("y1",     y1,    m_y(1));
      chk("yv1",    yv1,   {7'd0, |m_y(1)});
      chk("done1",  done1, {7'd0, m_done(1)});
      chk("rdy1",   rdy1,  {7'd0, m_rdy(1)});
      for (int d = 0; d < 2; d++) begin
         if (!en) begin
            act[d] = 1'b0;
         end else if (in_valid && m_rdy(d)) begin
            act[d]      = 1'b1;
            acc_t[d]    = cyc;
            acc_code[d] = int'(code);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // asynchronous reset pulse landing between edges
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      chk("arst_y0",    y0,    8'h00);
      chk("arst_done0", done0, 8'h00);
      chk("arst_rdy0",  rdy0,  {7'd0, en});
      chk("arst_y1",    y1,    8'h00);
      chk("arst_done1", done1, 8'h00);
      rst = 1'b0;
      act[0] = 1'b0;
      act[1] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; code = '0;
      act[0] = 1'b0; act[1] = 1'b0;
      acc_t[0] = 0; acc_t[1] = 0; acc_code[0] = 0; acc_code[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y0",    y0,    8'h00);
      chk("rst_yv0",   yv0,   8'h00);
      chk("rst_done0", done0, 8'h00);
      chk("rst_y1",    y1,    8'h00);
      rst = 1'b0;

      // code 5, then code wanders during hold/gap without effect
      en = 1'b1; in_valid = 1'b1; code = 3'd5;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         code = 3'($urandom);
         step();
         chk("p5_y",    s_y0,    (i <= 4) ? 8'h20 : 8'h00);
         chk("p5_done", s_done0, {7'd0, i == 4});
         chk("p5_rdy",  s_rdy0,  {7'd0, i >= 6});
      end

      // back-to-back valid: 0 then 7, second accepted six cycles later
      in_valid = 1'b1; code = 3'd0;
      step();
      code = 3'd7;
      for (int i = 1; i <= 11; i++) begin
         if (i == 7) in_valid = 1'b0;
         step();
         if (i == 6) chk("b2b_rdy6", s_rdy0, 8'h01);
         if (i >= 7 && i <= 10) chk("b2b_y", s_y0, 8'h80);
      end
      in_valid = 1'b0;
      repeat (3) step();

      // enable dropped on the 2nd hold cycle
      in_valid = 1'b1; code = 3'd3;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         en = (i != 2);
         step();
         chk("abort_done", s_done0, 8'h00);
         if (i == 3) chk("abort_y3", s_y0, 8'h00);
         if (i == 3) chk("abort_rdy3", s_rdy0, 8'h01);
      end

      // async reset in the middle of a hold
      in_valid = 1'b1; code = 3'd6;
      step();
      in_valid = 1'b0;
      step();
      chk("pre_rst_y", s_y0, 8'h40);
      step();
      async_reset();
      step();
      chk("post_rst_rdy", s_rdy0, 8'h01);
      repeat (6) step();

      // fast instance streams all 8 codes, one accept every 2 cycles
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         code = 3'(i / 2);
         step();
         if (i % 2 == 1) begin
            logic [W-1:0] e;
            e = 8'h01 << (i / 2);
            chk("stream_y", s_y1, e);
            chk("stream_done", s_done1, 8'h01);
         end else if (i > 0) begin
            chk("stream_gap", s_y1, 8'h00);
            chk("stream_rdy", s_rdy1, 8'h01);
         end
      end
      in_valid = 1'b0;
      repeat (6) step();

      // randomized traffic with occasional enable drops and async resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(63) == 0) async_reset();
         en       = ($urandom_range(9) != 0);
         in_valid = ($urandom_range(2) != 0);
         code     = 3'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode38_hold.md
DECODE38_HOLD -- requirements
Module: decode38_hold

Interface
REQ-001 Parameter N, default 3, code width; output width 2**N.
REQ-002 Parameter HOLD, default 4, cycles a decoded line stays asserted (>=1).
REQ-003 Parameter GAP, default 1, all-zero cycles forced after each hold (>=0).
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  enable; low forces idle and all-zero output.
REQ-007 in_valid  input  1  code is presented.
REQ-008 in_ready  output  1  block accepts a code this cycle.
REQ-009 code  input  N  binary index to decode.
REQ-010 y  output  2**N  registered one-hot decoded output.
REQ-011 y_valid  output  1  high exactly when y is nonzero.
REQ-012 done  output  1  one-cycle pulse on the final HOLD cycle of a completed hold.

Function
REQ-013 FSM states IDLE, HOLD, GAP; a single down-counter, width clog2(max(HOLD,GAP)+1), times HOLD and GAP.
REQ-014 in_ready = en && state==IDLE (combinational); accept = in_valid && in_ready.
REQ-015 On accept at edge k: y = one-hot(code) with bit[code]=1 and all others 0, from cycle k+1; state -> HOLD; counter = HOLD-1.
REQ-016 code is sampled only at accept; changes on code during HOLD/GAP have no effect.
REQ-017 HOLD: y held constant; counter decrements each cycle; y asserted for exactly HOLD cycles.
REQ-018 done = 1 in the HOLD cycle where counter==0 and en==1; 0 otherwise.
REQ-019 Leaving HOLD with GAP>0: y=0, state GAP, counter = GAP-1; GAP lasts exactly GAP cycles, then IDLE.
REQ-020 Leaving HOLD with GAP==0: y=0, state IDLE.
REQ-021 Minimum accept-to-accept spacing is HOLD+GAP+1 cycles; in_ready low throughout HOLD and GAP.
REQ-022 en low in any state: next cycle y=0, state IDLE, counter=0; no done pulse (abort).
REQ-023 en low while in_valid high in IDLE: no accept, y stays 0.
REQ-024 y_valid = |y; y is never multi-hot.
REQ-025 Every code value 0..2**N-1 is legal; no out-of-range case exists.

Reset
REQ-026 rst high asynchronously forces state IDLE, counter 0, y 0, y_valid 0, done 0.
REQ-027 rst asserted mid-HOLD or mid-GAP aborts the operation immediately; no done.
REQ-028 After rst deasserts, in_ready follows en on the first clock edge.

Structure
REQ-029 Shared package/header holds state encodings (IDLE=0, HOLD=1, GAP=2, 2-bit) and the counter-width function.
REQ-030 One combinational sub-module dec_onehot (N-bit in, 2**N one-hot out, en gate) provides decoding; the FSM registers its output.
REQ-031 Outputs y and done come from flops or state only; no combinational path from code to y.

Verification
REQ-032 Defaults, en=1, code=5 valid at cycle 0 -> y=8'b0010_0000 cycles 1-4, done at cycle 4, y=0 cycle 5, in_ready high cycle 6.
REQ-033 Back-to-back in_valid with codes 0,7 -> code 7 accepted at cycle 6; y=8'h80 cycles 7-10.
REQ-034 code switched 5->2 during HOLD -> y stays 8'h20 for the full hold.
REQ-035 en dropped at cycle 2 of a hold -> y=0 at cycle 3, no done, in_ready high once en returns.
REQ-036 rst pulsed asynchronously mid-HOLD -> y=0, done=0 before the next edge; state IDLE.
REQ-037 HOLD=1, GAP=0, all 8 codes streamed -> one accept every 2 cycles; y walks 01,02,...,80 with zero cycles between.
